cla_seq_adder_ctrl: RTL and testbench
=====================================

Name: cla_seq_adder_ctrl

Overview:
Multi-cycle controller that performs WIDTH-bit add/subtract by time-multiplexing a single existing cla_4bit slice, one 4-bit nibble per cycle, LSB first, carry registered between cycles.
Valid/ready handshake on both input and output sides.
Sits between a requester (ALU sequencer/testbench driver) and the shared 4-bit CLA datapath; trades latency for area.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and >= 4 (elaboration error otherwise)
NSLICE, WIDTH/4, derived local constant: number of nibble passes

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand bundle valid
in_ready  output  1  controller can accept operands (high only in IDLE)
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in for add; ignored when sub=1
sub  input  1  1 = compute a - b (b inverted, carry-in forced 1)
out_valid  output  1  result bundle valid
out_ready  input  1  consumer accepts result
sum  output  WIDTH  result
cout  output  1  carry out of MSB (for sub: 1 = no borrow)
ovf  output  1  signed two's-complement overflow
busy  output  1  high in RUN or DONE

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE, nibble index=0, carry reg=0, sum=0, cout=0, ovf=0, out_valid=0, busy=0; in_ready=1 from the first cycle after reset. Reset mid-RUN/DONE aborts; partial result is discarded and is never presented.
- States:
  - IDLE: in_ready=1. On in_valid at an edge:
    - latch a_reg=a; b_reg = sub ? ~b : b; carry = sub ? 1 : cin; idx=0.
    - Go to RUN.
  - RUN: cla_4bit is driven with a_reg[4*idx+:4], b_reg[4*idx+:4], carry. At each edge:
    - sum_reg[4*idx+:4] <= slice sum; carry <= slice cout; idx <= idx+1.
    - On the edge where idx==NSLICE-1, go to DONE, register cout, and compute ovf = (a_reg[MSB]==b_reg[MSB]) && (final sum[MSB]!=a_reg[MSB]).
  - DONE: out_valid=1, sum/cout/ovf held stable. On out_ready at an edge, go to IDLE and out_valid falls.
- Latency: with the accept edge at T0, out_valid is high exactly NSLICE cycles later, after edge T0+NSLICE. Throughput is one operation per NSLICE+2 cycles minimum; there is no overlap.
- in_valid while not in IDLE: ignored (in_ready=0). The requester must hold operands until it sees in_ready.
- out_ready while not in DONE: ignored.
- Backpressure: DONE is held indefinitely; outputs must not change until the handshake completes.
- Outputs are registered only; no combinational path from in_valid/out_ready to out_valid. in_ready and busy are decoded from the state register.
- Arithmetic is modulo 2^WIDTH; overflow is reported only via cout/ovf, never saturated.
- sum retains the last result after returning to IDLE until the next operation overwrites it. Nibble writes are internal; the sum port is driven from a register updated only on DONE entry, so no partially written value is visible.

Decomposition:
- Shared package cla_pkg:
  - state enum {IDLE, RUN, DONE}
  - SLICE_W=4
  - function clog2 for the idx width (max(1, clog2(NSLICE)))
- Sub-module: instantiate existing cla_4bit once as the datapath; no new sub-module.
- The controller (FSM, idx counter, operand/carry/result registers) is a single module.

Test Plan:
- WIDTH=16, add: a=0x1234, b=0x4321, cin=0, accept at T0 -> out_valid rises after T0+4; sum=0x5555, cout=0, ovf=0.
- Carry chain across all nibbles: a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1, ovf=0.
- Signed overflow: a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1.
- Subtract: a=0x0005, b=0x0007, sub=1, cin=1 (ignored) -> sum=0xFFFE, cout=0 (borrow), ovf=0; then a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, cout=1, ovf=1.
- Backpressure/handshake: hold out_ready=0 for 10 cycles in DONE -> out_valid, sum and cout are stable and in_ready=0, and a second in_valid is ignored. Raise out_ready -> IDLE next cycle, then accept the second operation.
- Reset mid-operation: assert rst at the second RUN edge -> next cycle state=IDLE, out_valid=0, sum=0, in_ready=1. A fresh add of 0x0001+0x0001 then yields 0x0002 with no stale carry.

Source files
------------

// File: rtl/cla_pkg.sv
// Shared types and helpers for the nibble-serial CLA adder controller.
package cla_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int SLICE_W = 4;

    // Width of a counter that indexes n items; never less than one bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/cla_4bit.sv
// 4-bit carry-lookahead adder slice shared by the sequential controller.
module cla_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [3:0] g, p;
    logic [4:0] c;

    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);
        sum  = p ^ c[3:0];
        cout = c[4];
    end

endmodule

// File: rtl/cla_seq_adder_ctrl.sv
// WIDTH-bit add/subtract built by running one cla_4bit slice over the operand
// nibbles LSB first, with the carry held in a register between passes.
module cla_seq_adder_ctrl
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int IDXW   = clog2(NSLICE);

    generate
        if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_bad_width
            $error("cla_seq_adder_ctrl: WIDTH must be a positive multiple of 4");
        end
    endgenerate

    state_t            state;
    logic [IDXW-1:0]   idx;
    logic [WIDTH-1:0]  a_reg, b_reg, work, work_nxt;
    logic              carry;
    logic [SLICE_W-1:0] s_a, s_b, s_sum;
    logic              s_cout;
    logic              last;

    assign s_a  = a_reg[SLICE_W*idx +: SLICE_W];
    assign s_b  = b_reg[SLICE_W*idx +: SLICE_W];
    assign last = (idx == IDXW'(NSLICE - 1));

    cla_4bit u_slice (
        .a   (s_a),
        .b   (s_b),
        .cin (carry),
        .sum (s_sum),
        .cout(s_cout)
    );

    // Merged result including the nibble being produced this cycle, so the
    // final pass can publish the complete value straight into the sum port.
    always_comb begin
        work_nxt = work;
        work_nxt[SLICE_W*idx +: SLICE_W] = s_sum;
    end

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            carry     <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            work      <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= a;
                        b_reg <= sub ? ~b : b;
                        carry <= sub ? 1'b1 : cin;
                        idx   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    work  <= work_nxt;
                    carry <= s_cout;
                    idx   <= idx + 1'b1;
                    if (last) begin
                        idx       <= '0;
                        sum       <= work_nxt;
                        cout      <= s_cout;
                        ovf       <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                                     (work_nxt[WIDTH-1] != a_reg[WIDTH-1]);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cla_seq_adder_ctrl.sv
// Randomized scoreboard bench for the nibble-serial adder controller.
module tb_cla_seq_adder_ctrl;

    localparam int W  = 16;
    localparam int NS = W / 4;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         busy;

    cla_seq_adder_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .ovf      (ovf),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int   nchk = 0;
    int   nfail = 0;
    int   cyc = 0;
    bit   bp_hold = 1'b0;
    exp_t sbq[$];
    int   accq[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain integer arithmetic on the operands.
    function automatic exp_t model(logic [W-1:0] xa, logic [W-1:0] xb, logic xc, logic xs);
        exp_t   e;
        longint ua, ub, u, sa, sb, r;
        ua = longint'(xa);
        ub = longint'(xb);
        sa = longint'($signed(xa));
        sb = longint'($signed(xb));
        if (xs) begin
            u   = (ua - ub) & ((64'sd1 <<< W) - 1);
            e.c = (ua >= ub);
            r   = sa - sb;
        end else begin
            u   = ua + ub + longint'(xc);
            e.c = (u >= (64'sd1 <<< W));
            r   = sa + sb + longint'(xc);
        end
        e.s = u[W-1:0];
        e.o = (r > ((64'sd1 <<< (W-1)) - 1)) || (r < -(64'sd1 <<< (W-1)));
        return e;
    endfunction

    task automatic check(string nm, logic [31:0] act, logic [31:0] expv);
        nchk++;
        if (act !== expv) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    task automatic fail_now(string nm);
        nchk++;
        nfail++;
        $display("FAIL %s: bound expired", nm);
    endtask

    // out_ready driver: random acceptance unless backpressure is being held.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            out_ready = bp_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: latency on every out_valid rise, payload on every handshake.
    initial begin
        bit prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (out_valid && !prev) begin
                    if (accq.size() == 0) fail_now("unexpected_out_valid");
                    else begin
                        int t;
                        t = accq.pop_front();
                        check("latency", 32'(cyc - t), NS);
                    end
                end
                if (out_valid && out_ready) begin
                    if (sbq.size() == 0) fail_now("unexpected_result");
                    else begin
                        exp_t e;
                        e = sbq.pop_front();
                        check("sum", 32'(sum), 32'(e.s));
                        check("cout", 32'(cout), 32'(e.c));
                        check("ovf", 32'(ovf), 32'(e.o));
                    end
                end
            end
            prev = out_valid;
        end
    end

    task automatic send(logic [W-1:0] xa, logic [W-1:0] xb, logic xc, logic xs, bit push);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            fail_now("send_wait_in_ready");
            return;
        end
        a = xa; b = xb; cin = xc; sub = xs; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (push) begin
            sbq.push_back(model(xa, xb, xc, xs));
            accq.push_back(cyc);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sbq.size() != 0 || out_valid) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0) fail_now("drain");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   n;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_sum", 32'(sum), 0);
        check("rst_cout_ovf", {30'd0, cout, ovf}, 0);

        // Directed corners.
        send(16'h1234, 16'h4321, 1'b0, 1'b0, 1);
        send(16'hFFFF, 16'h0000, 1'b1, 1'b0, 1);
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1);
        send(16'h0005, 16'h0007, 1'b1, 1'b1, 1);
        send(16'h8000, 16'h0001, 1'b0, 1'b1, 1);
        drain();

        // Backpressure: DONE held, outputs stable, extra in_valid ignored.
        bp_hold = 1'b1;
        @(posedge clk);
        send(16'h0F0F, 16'h0101, 1'b0, 1'b0, 1);
        e = model(16'h0F0F, 16'h0101, 1'b0, 1'b0);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) fail_now("bp_wait_valid");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_out_valid", 32'(out_valid), 1);
            check("bp_sum", 32'(sum), 32'(e.s));
            check("bp_cout", 32'(cout), 32'(e.c));
            check("bp_in_ready", 32'(in_ready), 0);
            if (i == 0) begin
                a = 16'hAAAA; b = 16'h5555; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
            end
        end
        in_valid = 1'b0;
        bp_hold = 1'b0;
        drain();
        send(16'h2222, 16'h3333, 1'b0, 1'b1, 1);
        drain();

        // Reset during RUN discards the operation.
        send(16'h1111, 16'h2222, 1'b0, 1'b0, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("mid_rst_in_ready", 32'(in_ready), 1);
        check("mid_rst_out_valid", 32'(out_valid), 0);
        check("mid_rst_sum", 32'(sum), 0);
        check("mid_rst_busy", 32'(busy), 0);
        send(16'h0001, 16'h0001, 1'b0, 1'b0, 1);
        drain();

        // Random traffic with random acceptance.
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra, rb;
            logic         rc, rs;
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            send(ra, rb, rc, rs, 1);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
